// File: rtl/rs_dispatch_sched.sv
// rtl/rs_dispatch_sched.sv - per-class RS allocator, oldest-ready dispatcher and CDB writeback sequencer
module rs_dispatch_sched #(
    parameter int N_ENTRIES = 3,
    parameter int IDX_W     = 2,
    parameter int LATENCY   = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 issue_valid_i,
    output logic                 issue_ready_o,
    output logic [IDX_W-1:0]     issue_idx_o,
    input  logic [N_ENTRIES-1:0] entry_ready_i,
    output logic [N_ENTRIES-1:0] busy_vec_o,
    output logic                 disp_valid_o,
    output logic [IDX_W-1:0]     disp_idx_o,
    output logic                 fu_busy_o,
    output logic                 cdb_req_o,
    input  logic                 cdb_grant_i,
    output logic [IDX_W-1:0]     cdb_tag_o,
    output logic [N_ENTRIES-1:0] entry_free_o
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_WB
    } state_t;

    state_t                           state_q, state_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [IDX_W-1:0]                 cur_q, cur_d;
    logic [N_ENTRIES-1:0]             busy_q, busy_d;
    logic [N_ENTRIES-1:0]             disp_q, disp_d;
    // age_q[j][i] = 1 means entry j is older than entry i
    logic [N_ENTRIES-1:0][N_ENTRIES-1:0] age_q, age_d;

    logic [N_ENTRIES-1:0] elig;
    logic [N_ENTRIES-1:0] blocked;
    logic [IDX_W-1:0]     win_idx;
    logic                 any_elig;
    logic                 issue_fire;
    logic                 grant_fire;

    assign busy_vec_o    = busy_q;
    assign issue_ready_o = ~(&busy_q);
    assign issue_fire    = issue_valid_i & issue_ready_o;
    assign elig          = busy_q & entry_ready_i & ~disp_q;
    assign disp_idx_o    = win_idx;
    assign cdb_tag_o     = cur_q;

    always_comb begin
        issue_idx_o = '0;
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                issue_idx_o = IDX_W'(i);
            end
        end
    end

    // An eligible entry is blocked if any other eligible entry is older.
    always_comb begin
        blocked = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            for (int j = 0; j < N_ENTRIES; j++) begin
                if (elig[j] && age_q[j][i]) begin
                    blocked[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        win_idx  = '0;
        any_elig = 1'b0;
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (elig[i] && !blocked[i]) begin
                win_idx  = IDX_W'(i);
                any_elig = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cur_d        = cur_q;
        disp_valid_o = 1'b0;
        fu_busy_o    = 1'b0;
        cdb_req_o    = 1'b0;
        grant_fire   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_elig) begin
                    disp_valid_o = 1'b1;
                    cur_d        = win_idx;
                    cnt_d        = CNT_W'(LATENCY - 1);
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                fu_busy_o = 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_WB;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_WB: begin
                fu_busy_o = 1'b1;
                cdb_req_o = 1'b1;
                if (cdb_grant_i) begin
                    grant_fire = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        entry_free_o = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            entry_free_o[i] = grant_fire && (cur_q == IDX_W'(i));
        end
    end

    // Freeing is applied after allocation so a cleared row/column always wins.
    always_comb begin
        busy_d = busy_q;
        disp_d = disp_q;
        age_d  = age_q;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (issue_fire && issue_idx_o == IDX_W'(i)) begin
                busy_d[i] = 1'b1;
                for (int j = 0; j < N_ENTRIES; j++) begin
                    age_d[j][i] = busy_q[j];
                    age_d[i][j] = 1'b0;
                end
            end
            if (disp_valid_o && win_idx == IDX_W'(i)) begin
                disp_d[i] = 1'b1;
            end
        end
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (grant_fire && cur_q == IDX_W'(i)) begin
                busy_d[i] = 1'b0;
                disp_d[i] = 1'b0;
                for (int j = 0; j < N_ENTRIES; j++) begin
                    age_d[j][i] = 1'b0;
                    age_d[i][j] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cur_q   <= '0;
            busy_q  <= '0;
            disp_q  <= '0;
            age_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cur_q   <= cur_d;
            busy_q  <= busy_d;
            disp_q  <= disp_d;
            age_q   <= age_d;
        end
    end

endmodule

// File: tb/tb_rs_dispatch_sched.sv
// tb/tb_rs_dispatch_sched.sv - directed bench for rs_dispatch_sched (N_ENTRIES=3, LATENCY=2)
module tb_rs_dispatch_sched;

    logic       clk;
    logic       rst;
    logic       issue_valid;
    logic       issue_ready;
    logic [1:0] issue_idx;
    logic [2:0] entry_ready;
    logic [2:0] busy_vec;
    logic       disp_valid;
    logic [1:0] disp_idx;
    logic       fu_busy;
    logic       cdb_req;
    logic       cdb_grant;
    logic [1:0] cdb_tag;
    logic [2:0] entry_free;

    int n_checks = 0;
    int n_fail   = 0;

    rs_dispatch_sched #(.N_ENTRIES(3), .IDX_W(2), .LATENCY(2)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .issue_valid_i (issue_valid),
        .issue_ready_o (issue_ready),
        .issue_idx_o   (issue_idx),
        .entry_ready_i (entry_ready),
        .busy_vec_o    (busy_vec),
        .disp_valid_o  (disp_valid),
        .disp_idx_o    (disp_idx),
        .fu_busy_o     (fu_busy),
        .cdb_req_o     (cdb_req),
        .cdb_grant_i   (cdb_grant),
        .cdb_tag_o     (cdb_tag),
        .entry_free_o  (entry_free)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    initial begin
        rst = 1'b1; issue_valid = 1'b0; entry_ready = 3'b000; cdb_grant = 1'b0;
        tick; tick;
        rst = 1'b0; settle;
        chk("rst_busy", 32'(busy_vec), 32'h0);
        chk("rst_issue_ready", 32'(issue_ready), 32'h1);
        chk("rst_issue_idx", 32'(issue_idx), 32'h0);
        chk("rst_disp_valid", 32'(disp_valid), 32'h0);
        chk("rst_cdb_req", 32'(cdb_req), 32'h0);
        chk("rst_fu_busy", 32'(fu_busy), 32'h0);
        chk("rst_cdb_tag", 32'(cdb_tag), 32'h0);
        chk("rst_entry_free", 32'(entry_free), 32'h0);

        issue_valid = 1'b1; settle;
        chk("alloc0_idx", 32'(issue_idx), 32'h0);
        tick;
        chk("alloc1_busy", 32'(busy_vec), 32'h1);
        chk("alloc1_idx", 32'(issue_idx), 32'h1);
        tick;
        chk("alloc2_idx", 32'(issue_idx), 32'h2);
        tick;
        chk("full_busy", 32'(busy_vec), 32'h7);
        chk("full_ready", 32'(issue_ready), 32'h0);
        chk("full_idx", 32'(issue_idx), 32'h0);
        chk("full_no_disp", 32'(disp_valid), 32'h0);
        tick;
        issue_valid = 1'b0;
        chk("full_busy_hold", 32'(busy_vec), 32'h7);

        entry_ready = 3'b110; settle;
        chk("oldest_disp_valid", 32'(disp_valid), 32'h1);
        chk("oldest_disp_idx", 32'(disp_idx), 32'h1);
        tick;
        chk("exec1_fu_busy", 32'(fu_busy), 32'h1);
        chk("exec1_no_disp", 32'(disp_valid), 32'h0);
        chk("exec1_no_req", 32'(cdb_req), 32'h0);
        tick;
        chk("exec2_no_req", 32'(cdb_req), 32'h0);
        for (int s = 0; s < 3; s++) begin
            tick;
            chk($sformatf("stall%0d_req", s), 32'(cdb_req), 32'h1);
            chk($sformatf("stall%0d_tag", s), 32'(cdb_tag), 32'h1);
            chk($sformatf("stall%0d_free", s), 32'(entry_free), 32'h0);
        end
        tick;
        cdb_grant = 1'b1; issue_valid = 1'b1; settle;
        chk("grant_free", 32'(entry_free), 32'h2);
        chk("grant_ready_still0", 32'(issue_ready), 32'h0);
        chk("grant_busy_still", 32'(busy_vec), 32'h7);
        tick;
        cdb_grant = 1'b0; settle;
        chk("post_grant_busy", 32'(busy_vec), 32'h5);
        chk("race_ready", 32'(issue_ready), 32'h1);
        chk("race_idx", 32'(issue_idx), 32'h1);
        chk("next_disp_valid", 32'(disp_valid), 32'h1);
        chk("next_disp_idx", 32'(disp_idx), 32'h2);
        chk("post_grant_req", 32'(cdb_req), 32'h0);
        tick;
        issue_valid = 1'b0; settle;
        chk("realloc_busy", 32'(busy_vec), 32'h7);
        tick; tick;
        cdb_grant = 1'b1; settle;
        chk("wb2_tag", 32'(cdb_tag), 32'h2);
        chk("wb2_free", 32'(entry_free), 32'h4);
        tick;
        cdb_grant = 1'b0; entry_ready = 3'b011; settle;
        chk("wb2_busy_after", 32'(busy_vec), 32'h3);
        chk("age_disp_valid", 32'(disp_valid), 32'h1);
        chk("age_disp_idx", 32'(disp_idx), 32'h0);
        tick; tick; tick;
        chk("wb3_req", 32'(cdb_req), 32'h1);
        chk("wb3_tag", 32'(cdb_tag), 32'h0);

        rst = 1'b1;
        tick;
        rst = 1'b0; settle;
        chk("midrst_req", 32'(cdb_req), 32'h0);
        chk("midrst_busy", 32'(busy_vec), 32'h0);
        chk("midrst_fu_busy", 32'(fu_busy), 32'h0);
        chk("midrst_no_disp", 32'(disp_valid), 32'h0);

        issue_valid = 1'b1; entry_ready = 3'b001; settle;
        chk("newent_idx", 32'(issue_idx), 32'h0);
        chk("newent_no_disp_same", 32'(disp_valid), 32'h0);
        tick;
        issue_valid = 1'b0; settle;
        chk("newent_disp_valid", 32'(disp_valid), 32'h1);
        chk("newent_disp_idx", 32'(disp_idx), 32'h0);
        tick;
        cdb_grant = 1'b1; settle;
        chk("stray_grant_exec1", 32'(entry_free), 32'h0);
        tick;
        chk("stray_grant_exec2", 32'(entry_free), 32'h0);
        tick;
        chk("wb4_free", 32'(entry_free), 32'h1);
        tick;
        cdb_grant = 1'b0; settle;
        chk("final_busy", 32'(busy_vec), 32'h0);
        chk("final_fu_busy", 32'(fu_busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
